// File: rtl/simd_dramwd_sink.sv
// ---------------------------------------------------------------------------
// simd_dramwd_sink
//
// Receiver end of the SIMD ALU dramwd stream. A job descriptor (base address,
// stride, vector count) is taken on the cfg port. The block then accepts
// `count` vectors from the ALU into a small FIFO, tagging vector n with
// address base + n*stride. The vectors are forwarded in order on the DRAM
// write channel (dw). o_done_dval pulses once the last vector of the job has
// been handed to DRAM.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_cfg_rdy/o_cfg_ack   job descriptor handshake
//   i_cfg_addr            base address of vector 0
//   i_cfg_stride          address increment per vector (wraps mod 2^ABW)
//   i_cfg_count           number of vectors in the job (0 is legal)
//   i_dramwd_rdy/ack      ALU vector handshake, i_dramwd carries the vector
//   o_dw_rdy/i_dw_ack     DRAM write beat handshake
//   o_dw_addr/o_dw_data   beat address and data (registered head of FIFO)
//   o_done_dval           one-cycle job-complete pulse
//   o_busy                high whenever a job is in progress
// ---------------------------------------------------------------------------
module simd_dramwd_sink #(
  parameter int DBW    = 16,
  parameter int VSIZE  = 32,
  parameter int DEPTH  = 4,
  parameter int ABW    = 32,
  parameter int CNT_BW = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_cfg_rdy,
  output logic                          o_cfg_ack,
  input  logic [ABW-1:0]                i_cfg_addr,
  input  logic [ABW-1:0]                i_cfg_stride,
  input  logic [CNT_BW-1:0]             i_cfg_count,
  input  logic                          i_dramwd_rdy,
  output logic                          o_dramwd_ack,
  input  logic [VSIZE-1:0][DBW-1:0]     i_dramwd,
  output logic                          o_dw_rdy,
  input  logic                          i_dw_ack,
  output logic [ABW-1:0]                o_dw_addr,
  output logic [VSIZE-1:0][DBW-1:0]     o_dw_data,
  output logic                          o_done_dval,
  output logic                          o_busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [ABW-1:0]      cur_addr_reg;
  logic [ABW-1:0]      stride_reg;
  logic [CNT_BW-1:0]   count_reg;
  logic [CNT_BW-1:0]   n_in_reg;
  logic [CNT_BW-1:0]   n_out_reg;
  logic [PW-1:0]       wptr_reg;
  logic [PW-1:0]       rptr_reg;
  logic [CW-1:0]       fifo_cnt_reg;

  // FIFO storage: no reset needed, entries are only read once written.
  logic [ABW-1:0]              mem_addr [DEPTH];
  logic [VSIZE-1:0][DBW-1:0]   mem_data [DEPTH];

  logic                        cfg_fire;
  logic                        push;
  logic                        pop;
  logic [CW-1:0]               cnt_after_pop;
  logic [PW-1:0]               rptr_next;
  logic                        head_load;
  logic [ABW-1:0]              head_addr_next;
  logic [VSIZE-1:0][DBW-1:0]   head_data_next;

  assign o_dw_rdy = (fifo_cnt_reg != '0);
  assign o_busy   = (state_reg != ST_IDLE);
  assign cfg_fire = o_cfg_ack;
  assign push     = o_dramwd_ack;
  assign pop      = o_dw_rdy && i_dw_ack;

  // -------------------------------------------------------------------------
  // Control FSM: next state and handshake outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    o_cfg_ack    = 1'b0;
    o_dramwd_ack = 1'b0;
    o_done_dval  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Gated by reset so the ack reads 0 the moment reset is asserted.
        o_cfg_ack = i_cfg_rdy && !i_rst;
        if (o_cfg_ack) begin
          state_next = (i_cfg_count == '0) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        // fifo_cnt_reg is the registered occupancy: a pop this cycle does not
        // open a slot until the next one.
        o_dramwd_ack = i_dramwd_rdy && (fifo_cnt_reg < CW'(DEPTH))
                       && (n_in_reg < count_reg);
        if (o_dramwd_ack && (n_in_reg == count_reg - 1'b1)) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((fifo_cnt_reg == '0) && (n_out_reg == count_reg)) begin
          o_done_dval = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Next head-of-FIFO value for the registered dw outputs. When the FIFO will
  // be non-empty after this cycle's pop, the new head is either an entry that
  // is already stored, or (when the pop leaves nothing behind) the vector
  // being pushed right now. When the FIFO goes empty the outputs hold.
  // -------------------------------------------------------------------------
  assign cnt_after_pop = fifo_cnt_reg - CW'(pop);
  assign rptr_next     = rptr_reg + PW'(pop);

  always_comb begin
    head_load      = 1'b0;
    head_addr_next = o_dw_addr;
    head_data_next = o_dw_data;
    if (cnt_after_pop != '0) begin
      head_load      = 1'b1;
      head_addr_next = mem_addr[rptr_next];
      head_data_next = mem_data[rptr_next];
    end else if (push) begin
      head_load      = 1'b1;
      head_addr_next = cur_addr_reg;
      head_data_next = i_dramwd;
    end
  end

  // -------------------------------------------------------------------------
  // State, counters, pointers and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg    <= ST_IDLE;
      cur_addr_reg <= '0;
      stride_reg   <= '0;
      count_reg    <= '0;
      n_in_reg     <= '0;
      n_out_reg    <= '0;
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      fifo_cnt_reg <= '0;
      o_dw_addr    <= '0;
      o_dw_data    <= '0;
    end else begin
      state_reg <= state_next;

      // cfg is only accepted in IDLE, where the FIFO is empty, so it never
      // coincides with a push or pop.
      if (cfg_fire) begin
        cur_addr_reg <= i_cfg_addr;
        stride_reg   <= i_cfg_stride;
        count_reg    <= i_cfg_count;
        n_in_reg     <= '0;
        n_out_reg    <= '0;
      end else begin
        if (push) begin
          cur_addr_reg <= cur_addr_reg + stride_reg;
          n_in_reg     <= n_in_reg + 1'b1;
        end
        if (pop) begin
          n_out_reg <= n_out_reg + 1'b1;
        end
      end

      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wptr_reg <= wptr_reg + 1'b1;
      if (pop)  rptr_reg <= rptr_reg + 1'b1;

      case ({push, pop})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 1'b1;
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 1'b1;
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase

      if (head_load) begin
        o_dw_addr <= head_addr_next;
        o_dw_data <= head_data_next;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_addr[wptr_reg] <= cur_addr_reg;
      mem_data[wptr_reg] <= i_dramwd;
    end
  end

endmodule

// File: doc/simd_dramwd_sink.md
Name: simd_dramwd_sink

Overview:
- Receiver end of the SIMD ALU `dramwd` rdyack stream.
- Accepts one VSIZE-word vector per handshake into a small FIFO. Tags each vector with a strided DRAM address. Forwards it on the DRAM write channel (`dw`).
- Programmed per job through a `cfg` rdyack port. Pulses `done` once the last vector of the job has been handed to DRAM.
- Sits between the tile accumulation unit ALU pipeline and the DRAM write arbiter.

Parameters:
- DBW, 16, data word width (matches TauCfg::DATA_BW)
- VSIZE, 32, words per vector (matches TauCfg::VECTOR_SIZE)
- DEPTH, 4, FIFO entries in vectors; power of two, ≥2
- ABW, 32, DRAM address width
- CNT_BW, 16, vector-count width per job

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset; asynchronous, active-high
- i_cfg_rdy  input  1  job descriptor valid
- o_cfg_ack  output  1  job descriptor accepted
- i_cfg_addr  input  ABW  base address of vector 0
- i_cfg_stride  input  ABW  address increment per vector
- i_cfg_count  input  CNT_BW  vectors in job; 0 is legal
- i_dramwd_rdy  input  1  ALU vector valid
- o_dramwd_ack  output  1  ALU vector accepted
- i_dramwd  input  DBW x [VSIZE]  ALU vector
- o_dw_rdy  output  1  DRAM write beat valid
- i_dw_ack  input  1  DRAM write beat accepted
- o_dw_addr  output  ABW  beat address
- o_dw_data  output  DBW x [VSIZE]  beat data
- o_done_dval  output  1  one-cycle job-complete pulse
- o_busy  output  1  state != IDLE

Behaviour:
- Handshake rule, all rdyack ports:
  - Transfer occurs on the cycle where rdy && ack.
  - ack is never high without rdy.
  - The sender holds rdy and data stable until ack.
  - rdy may stay high after ack to present the next item.
- Reset: async on i_rst high, effective immediately.
  - State IDLE, FIFO empty, counters 0.
  - o_cfg_ack=0, o_dramwd_ack=0, o_dw_rdy=0, o_dw_addr=0, o_dw_data=0, o_done_dval=0, o_busy=0.
  - Reset mid-job discards the job and any buffered vectors. No done pulse.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - o_cfg_ack = i_cfg_rdy (combinational).
  - On transfer, latch addr/stride/count and clear n_in and n_out.
  - count=0: go to DRAIN.
  - count>0: go to RUN.
- RUN:
  - o_dramwd_ack = i_dramwd_rdy && fifo_cnt < DEPTH && n_in < count.
  - fifo_cnt is registered. There is no full-bypass: a pop in the same cycle does not free space that cycle.
  - Each accepted vector is pushed with address cur_addr, then cur_addr += stride (mod 2^ABW) and n_in += 1.
  - When n_in reaches count, go to DRAIN.
- DRAIN:
  - No dramwd acks.
  - When fifo_cnt==0 and n_out==count, assert o_done_dval for exactly one cycle and return to IDLE.
  - A new cfg can be accepted no earlier than the cycle after done.
- FIFO output path (independent of state):
  - o_dw_rdy = fifo_cnt != 0.
  - o_dw_addr and o_dw_data are the head entry, taken from registers.
  - Pop on o_dw_rdy && i_dw_ack; n_out += 1.
  - Push and pop in the same cycle leave fifo_cnt unchanged.
  - Read and write pointers wrap modulo DEPTH.
- Latency: a vector accepted in cycle t is presented on o_dw_rdy in cycle t+1 at the earliest. Ordering is strictly FIFO.
- Throughput: 1 vector/cycle sustained when i_dw_ack is held high.
- Done timing: the done pulse occurs in the cycle after the final pop, or the cycle after cfg accept when count=0.
- Outputs hold their last value when o_dw_rdy=0.

Test Plan:
- Basic job:
  - Stimulus: cfg addr=0x1000, stride=0x40, count=3; dramwd vectors V0..V2 back-to-back; dw_ack tied 1.
  - Required: dw beats at 0x1000, 0x1040, 0x1080 carrying V0..V2 in order; each beat 1 cycle after its accept; done one cycle after the 3rd beat; busy low after.
- Backpressure/full:
  - Stimulus: count=6, dw_ack=0, dramwd_rdy held high.
  - Required: exactly 4 acks, then dramwd_ack=0 while fifo_cnt=4.
  - Then release dw_ack: 6 beats in order, done once.
- Zero count:
  - Stimulus: cfg count=0.
  - Required: cfg_ack 1 cycle, no dramwd_ack, no dw_rdy, done in the next cycle.
- Address wrap:
  - Stimulus: addr=0xFFFFFFC0, stride=0x40, count=2.
  - Required: beat addresses 0xFFFFFFC0 then 0x00000000.
- Random stalls:
  - Stimulus: random dramwd_rdy and dw_ack over count=100.
  - Required: scoreboard matches all data and addresses; no ack without rdy; rdy/data stable until ack; one done pulse.
- Reset mid-job:
  - Stimulus: assert i_rst after 2 of 5 vectors with FIFO non-empty.
  - Required: all outputs 0 immediately; no done; a new job with count=1 then completes normally.
